// File: rtl/elevator_scheduler.sv
// SCAN-policy car controller: travels in one direction while calls remain ahead,
// opens the door at each called floor and strobes serve to clear that floor's latch.
`timescale 1ns/1ps
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 8,
    parameter int FLOOR_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_n,
    input  logic [NUM_FLOORS-1:0] floor_sensor,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] serve,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  fault
);
    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT} state_t;

    localparam int CNT_W = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE_BIT   = NUM_FLOORS'(1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   dir_next;
    logic [NUM_FLOORS-1:0]  serve_next;
    logic [FLOOR_W-1:0]     floor_next;

    logic [NUM_FLOORS-1:0]  pend;
    logic [NUM_FLOORS-1:0]  above_cur, below_cur, above_f, below_f;
    logic [FLOOR_W-1:0]     sensor_idx;
    logic [4:0]             hot_cnt;
    logic                   one_hot, multi_hot;
    logic                   here, above, below, sensor_at_cur, at_f;

    assign pend = ~call_n;

    always_comb begin
        hot_cnt    = '0;
        sensor_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_sensor[i]) begin
                hot_cnt    = hot_cnt + 5'd1;
                sensor_idx = FLOOR_W'(i);
            end
        end
    end

    assign one_hot   = (hot_cnt == 5'd1);
    assign multi_hot = (hot_cnt > 5'd1);
    assign floor_next = one_hot ? sensor_idx : cur_floor;

    // Call masks relative to the latched floor (IDLE decisions) and to the floor
    // being passed right now (travel decisions).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign above_cur[gi] = pend[gi] & (FLOOR_W'(gi) > cur_floor);
            assign below_cur[gi] = pend[gi] & (FLOOR_W'(gi) < cur_floor);
            assign above_f[gi]   = pend[gi] & (FLOOR_W'(gi) > sensor_idx);
            assign below_f[gi]   = pend[gi] & (FLOOR_W'(gi) < sensor_idx);
        end
    endgenerate

    assign above         = |above_cur;
    assign below         = |below_cur;
    assign here          = pend[cur_floor];
    assign at_f          = pend[sensor_idx];
    assign sensor_at_cur = one_hot && (sensor_idx == cur_floor);

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_up;
        cnt_next   = cnt_reg;
        serve_next = '0;
        case (state_reg)
            IDLE: begin
                if (here && sensor_at_cur) begin
                    state_next = DOOR;
                end else if (dir_up && above) begin
                    state_next = MOVE_UP;
                end else if (!dir_up && below) begin
                    state_next = MOVE_DOWN;
                end else if (above) begin
                    state_next = MOVE_UP;
                    dir_next   = 1'b1;
                end else if (below) begin
                    state_next = MOVE_DOWN;
                    dir_next   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (one_hot) begin
                    if (at_f)
                        state_next = DOOR;
                    else if (!(|above_f) || sensor_idx == TOP_FLOOR)
                        state_next = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (one_hot) begin
                    if (at_f)
                        state_next = DOOR;
                    else if (!(|below_f) || sensor_idx == '0)
                        state_next = IDLE;
                end
            end
            DOOR: begin
                // The latch is still set in the cycle serve is high, so only a
                // call seen after the strobe counts as a re-press.
                if (here && !(|serve)) begin
                    cnt_next   = CNT_LOAD;
                    serve_next = ONE_BIT << cur_floor;
                end else if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            FAULT: state_next = FAULT;
            default: state_next = IDLE;
        endcase

        if (multi_hot) begin
            state_next = FAULT;
            serve_next = '0;
        end else if (state_next == DOOR && state_reg != DOOR) begin
            cnt_next   = CNT_LOAD;
            serve_next = ONE_BIT << floor_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            cur_floor  <= '0;
            dir_up     <= 1'b1;
            serve      <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cur_floor  <= floor_next;
            dir_up     <= dir_next;
            serve      <= serve_next;
            motor_up   <= (state_next == MOVE_UP);
            motor_down <= (state_next == MOVE_DOWN);
            door_open  <= (state_next == DOOR);
            fault      <= (state_next == FAULT);
        end
    end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: each scenario queues the expected sequence of output changes
// (with cycle gaps); a negedge monitor pops and compares on every output change.
`timescale 1ns/1ps
module tb_elevator_scheduler;
    logic       clk;
    logic       rst_n;
    logic [3:0] call_n;
    logic [3:0] floor_sensor;
    logic       motor_up, motor_down, door_open, dir_up, fault;
    logic [3:0] serve;
    logic [1:0] cur_floor;

    elevator_scheduler #(.NUM_FLOORS(4), .DOOR_CYCLES(8), .FLOOR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .call_n(call_n), .floor_sensor(floor_sensor),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .serve(serve), .cur_floor(cur_floor), .dir_up(dir_up), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {fault, motor_up, motor_down, door_open, serve, cur_floor, dir_up};

    function automatic logic [10:0] mk(input logic f, input logic mu, input logic md,
                                       input logic d, input logic [3:0] s,
                                       input logic [1:0] cf, input logic du);
        return {f, mu, md, d, s, cf, du};
    endfunction

    localparam logic [10:0] RESET_V = 11'b0000_0000_001;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] exp_v[$];
    int          exp_gap[$];
    string       exp_tag[$];

    task automatic expect_chg(input string tag, input logic [10:0] v, input int gap);
        exp_v.push_back(v);
        exp_gap.push_back(gap);
        exp_tag.push_back(tag);
    endtask

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end else
            $display("ok   %s: %b", tag, got);
    endtask

    // One clock; the call latch clears any floor the DUT is strobing.
    task automatic tick();
        @(posedge clk);
        #1;
        call_n = call_n | serve;
    endtask

    // Monitor
    initial begin
        logic [10:0] prev;
        logic [10:0] ev;
        int          eg, cyc, last_chg;
        string       et;
        prev     = RESET_V;
        cyc      = 0;
        last_chg = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (obs !== prev) begin
                compared++;
                if (exp_v.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_change: got %b want no change from %b", obs, prev);
                end else begin
                    ev = exp_v.pop_front();
                    eg = exp_gap.pop_front();
                    et = exp_tag.pop_front();
                    if (obs !== ev) begin
                        mismatched++;
                        $display("FAIL %s: got %b want %b", et, obs, ev);
                    end else
                        $display("ok   %s: %b after %0d cycles", et, obs, cyc - last_chg);
                    if (eg >= 0) begin
                        compared++;
                        if (cyc - last_chg != eg) begin
                            mismatched++;
                            $display("FAIL %s_gap: got %0d cycles want %0d", et, cyc - last_chg, eg);
                        end
                    end
                end
                prev     = obs;
                last_chg = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        call_n       = 4'b1111;
        floor_sensor = 4'b0001;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("reset_hold", obs, RESET_V);

        // A: floor 0 -> 3
        expect_chg("A_motor_up",   mk(0,1,0,0,4'b0000,2'd0,1), -1);
        expect_chg("A_pass_f1",    mk(0,1,0,0,4'b0000,2'd1,1), 1);
        expect_chg("A_pass_f2",    mk(0,1,0,0,4'b0000,2'd2,1), 1);
        expect_chg("A_door_f3",    mk(0,0,0,1,4'b1000,2'd3,1), 1);
        expect_chg("A_serve_end",  mk(0,0,0,1,4'b0000,2'd3,1), 1);
        expect_chg("A_door_close", mk(0,0,0,0,4'b0000,2'd3,1), 7);
        tick(); call_n = 4'b0111;
        tick(); floor_sensor = 4'b0010;
        tick(); floor_sensor = 4'b0100;
        tick(); floor_sensor = 4'b1000;
        repeat (12) tick();

        // Bd: floor 3 -> 0, direction flips, gap between floors holds cur_floor
        expect_chg("Bd_motor_down", mk(0,0,1,0,4'b0000,2'd3,0), -1);
        expect_chg("Bd_pass_f2",    mk(0,0,1,0,4'b0000,2'd2,0), 2);
        expect_chg("Bd_pass_f1",    mk(0,0,1,0,4'b0000,2'd1,0), 1);
        expect_chg("Bd_door_f0",    mk(0,0,0,1,4'b0001,2'd0,0), 1);
        expect_chg("Bd_serve_end",  mk(0,0,0,1,4'b0000,2'd0,0), 1);
        expect_chg("Bd_door_close", mk(0,0,0,0,4'b0000,2'd0,0), 7);
        tick(); call_n = 4'b1110;
        tick(); floor_sensor = 4'b0000;
        tick(); floor_sensor = 4'b0100;
        tick(); floor_sensor = 4'b0010;
        tick(); floor_sensor = 4'b0001;
        repeat (12) tick();

        // B: 0 -> 3 with floor 1 called as the car reaches it
        expect_chg("B_motor_up",    mk(0,1,0,0,4'b0000,2'd0,1), -1);
        expect_chg("B_door_f1",     mk(0,0,0,1,4'b0010,2'd1,1), 1);
        expect_chg("B_serve_end",   mk(0,0,0,1,4'b0000,2'd1,1), 1);
        expect_chg("B_door_close",  mk(0,0,0,0,4'b0000,2'd1,1), 7);
        expect_chg("B_resume_up",   mk(0,1,0,0,4'b0000,2'd1,1), 1);
        expect_chg("B_pass_f2",     mk(0,1,0,0,4'b0000,2'd2,1), 1);
        expect_chg("B_door_f3",     mk(0,0,0,1,4'b1000,2'd3,1), 1);
        expect_chg("B_serve_end3",  mk(0,0,0,1,4'b0000,2'd3,1), 1);
        expect_chg("B_door_close3", mk(0,0,0,0,4'b0000,2'd3,1), 7);
        tick(); call_n = 4'b0111;
        tick(); floor_sensor = 4'b0010; call_n = 4'b0101;
        repeat (10) tick(); floor_sensor = 4'b0100;
        tick(); floor_sensor = 4'b1000;
        repeat (12) tick();

        // C1: park at floor 2 heading down
        expect_chg("C_down_f2",     mk(0,0,1,0,4'b0000,2'd3,0), -1);
        expect_chg("C_door_f2",     mk(0,0,0,1,4'b0100,2'd2,0), 1);
        expect_chg("C_serve_end",   mk(0,0,0,1,4'b0000,2'd2,0), 1);
        expect_chg("C_door_close",  mk(0,0,0,0,4'b0000,2'd2,0), 7);
        tick(); call_n = 4'b1011;
        tick(); floor_sensor = 4'b0100;
        repeat (12) tick();

        // C2: calls at 0 and 3 from floor 2 going down: down first, then up
        expect_chg("C_keep_down",   mk(0,0,1,0,4'b0000,2'd2,0), -1);
        expect_chg("C_pass_f1",     mk(0,0,1,0,4'b0000,2'd1,0), 1);
        expect_chg("C_door_f0",     mk(0,0,0,1,4'b0001,2'd0,0), 1);
        expect_chg("C_serve_end0",  mk(0,0,0,1,4'b0000,2'd0,0), 1);
        expect_chg("C_door_close0", mk(0,0,0,0,4'b0000,2'd0,0), 7);
        expect_chg("C_turn_up",     mk(0,1,0,0,4'b0000,2'd0,1), 1);
        expect_chg("C_pass_f1u",    mk(0,1,0,0,4'b0000,2'd1,1), 1);
        expect_chg("C_pass_f2u",    mk(0,1,0,0,4'b0000,2'd2,1), 1);
        expect_chg("C_door_f3",     mk(0,0,0,1,4'b1000,2'd3,1), 1);
        expect_chg("C_serve_end3",  mk(0,0,0,1,4'b0000,2'd3,1), 1);
        expect_chg("C_door_close3", mk(0,0,0,0,4'b0000,2'd3,1), 7);
        tick(); call_n = 4'b0110;
        tick(); floor_sensor = 4'b0010;
        tick(); floor_sensor = 4'b0001;
        repeat (10) tick(); floor_sensor = 4'b0010;
        tick(); floor_sensor = 4'b0100;
        tick(); floor_sensor = 4'b1000;
        repeat (12) tick();

        // D: door at floor 1, re-press with counter at 2
        expect_chg("D_down",        mk(0,0,1,0,4'b0000,2'd3,0), -1);
        expect_chg("D_pass_f2",     mk(0,0,1,0,4'b0000,2'd2,0), 1);
        expect_chg("D_door_f1",     mk(0,0,0,1,4'b0010,2'd1,0), 1);
        expect_chg("D_serve_end",   mk(0,0,0,1,4'b0000,2'd1,0), 1);
        expect_chg("D_repress",     mk(0,0,0,1,4'b0010,2'd1,0), 5);
        expect_chg("D_serve_end2",  mk(0,0,0,1,4'b0000,2'd1,0), 1);
        expect_chg("D_door_close",  mk(0,0,0,0,4'b0000,2'd1,0), 7);
        tick(); call_n = 4'b1101;
        tick(); floor_sensor = 4'b0100;
        tick(); floor_sensor = 4'b0010;
        repeat (6) tick(); call_n[1] = 1'b0;
        repeat (12) tick();

        // E: multi-hot sensor while moving up, sticky fault, async reset
        expect_chg("E_up",          mk(0,1,0,0,4'b0000,2'd1,1), -1);
        expect_chg("E_fault",       mk(1,0,0,0,4'b0000,2'd1,1), 1);
        expect_chg("E_fault_floor", mk(1,0,0,0,4'b0000,2'd2,1), 1);
        expect_chg("E_async_reset", RESET_V, -1);
        expect_chg("E_post_reset",  mk(0,0,0,0,4'b0000,2'd2,1), -1);
        tick(); call_n = 4'b0111;
        tick(); floor_sensor = 4'b0110;
        tick(); floor_sensor = 4'b0100; call_n = 4'b1110;
        repeat (6) tick();
        check("E_fault_sticky", {8'b0, fault, motor_up, motor_down}, 11'b000_0000_0100);
        #2;
        call_n = 4'b1111;
        rst_n  = 1'b0;
        #1;
        check("E_async_reset_now", obs, RESET_V);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        compared++;
        if (exp_v.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drained: got %0d pending want 0 (next %s)", exp_v.size(), exp_tag[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
